layer_exec_responder: RTL

//   Layer-side end of the start_layer/done_layer handshake driven by main_controller.

---
 rtl/layer_exec_responder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/layer_exec_responder.sv
// rtl/layer_exec_responder.sv - layer-side tile walker for the start_layer/done_layer handshake
// Latches one layer's config, then launches filter-group/row/column tiles one at a time.
module layer_exec_responder #(
    parameter  int SYSTOLIC_SIZE = 16,
    parameter  int OFM_RAM_SIZE  = 2378675,
    localparam int ADDR_W        = $clog2(OFM_RAM_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        count_layer,
    input  logic [8:0]        ifm_size,
    input  logic [10:0]       ifm_channel,
    input  logic [1:0]        kernel_size,
    input  logic [10:0]       num_filter,
    input  logic              maxpool_mode,
    input  logic [1:0]        maxpool_stride,
    input  logic              upsample_mode,
    input  logic [ADDR_W-1:0] start_read_addr,
    input  logic [ADDR_W-1:0] start_write_addr,
    output logic              busy,
    output logic              done,
    output logic              tile_start,
    input  logic              tile_done,
    output logic [6:0]        tile_filter_idx,
    output logic [4:0]        tile_row_idx,
    output logic [4:0]        tile_col_idx,
    output logic [ADDR_W-1:0] tile_rd_addr,
    output logic [ADDR_W-1:0] tile_wr_addr,
    output logic [3:0]        cfg_count_layer,
    output logic [8:0]        cfg_ifm_size,
    output logic [10:0]       cfg_ifm_channel,
    output logic [1:0]        cfg_kernel_size,
    output logic [10:0]       cfg_num_filter,
    output logic              cfg_maxpool_mode,
    output logic [1:0]        cfg_maxpool_stride,
    output logic              cfg_upsample_mode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_ADV,
        S_FIN
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              tile_start_q;
    logic [6:0]        flt_q;
    logic [4:0]        row_q;
    logic [4:0]        col_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_row_q;
    logic [ADDR_W-1:0] wr_row_q;
    logic [ADDR_W-1:0] wr_flt_q;
    logic [ADDR_W-1:0] rd_base_q;
    logic [ADDR_W-1:0] wr_base_q;
    logic [ADDR_W-1:0] row_stride_q;
    logic [ADDR_W-1:0] flt_stride_q;
    logic [5:0]        nt_q;
    logic [7:0]        nf_q;

    logic [3:0]        cfg_count_layer_q;
    logic [8:0]        cfg_ifm_size_q;
    logic [10:0]       cfg_ifm_channel_q;
    logic [1:0]        cfg_kernel_size_q;
    logic [10:0]       cfg_num_filter_q;
    logic              cfg_maxpool_mode_q;
    logic [1:0]        cfg_maxpool_stride_q;
    logic              cfg_upsample_mode_q;

    logic [5:0]        nt_d;
    logic [7:0]        nf_d;
    logic [ADDR_W-1:0] row_stride_d;
    logic [ADDR_W-1:0] flt_stride_d;
    logic [ADDR_W-1:0] col_step;
    logic              col_last;
    logic              row_last;
    logic              flt_last;
    logic              walk_end;

    // Tile counts and strides derive from the already-latched config, so they are stable in LATCH.
    assign nt_d         = 6'((32'(cfg_ifm_size_q) + 32'(SYSTOLIC_SIZE) - 32'd1) / 32'(SYSTOLIC_SIZE));
    assign nf_d         = 8'((32'(cfg_num_filter_q) + 32'(SYSTOLIC_SIZE) - 32'd1) / 32'(SYSTOLIC_SIZE));
    assign row_stride_d = ADDR_W'(32'(cfg_ifm_size_q) * 32'(SYSTOLIC_SIZE));
    assign flt_stride_d = ADDR_W'(32'(cfg_ifm_size_q) * 32'(cfg_ifm_size_q) * 32'(SYSTOLIC_SIZE));
    assign col_step     = ADDR_W'(SYSTOLIC_SIZE);

    assign col_last = ({1'b0, col_q} + 6'd1) >= nt_q;
    assign row_last = ({1'b0, row_q} + 6'd1) >= nt_q;
    assign flt_last = ({1'b0, flt_q} + 8'd1) >= nf_q;
    assign walk_end = (nt_q == 6'd0) || (nf_q == 8'd0) || (col_last && row_last && flt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= S_IDLE;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            tile_start_q         <= 1'b0;
            flt_q                <= '0;
            row_q                <= '0;
            col_q                <= '0;
            rd_addr_q            <= '0;
            wr_addr_q            <= '0;
            rd_row_q             <= '0;
            wr_row_q             <= '0;
            wr_flt_q             <= '0;
            rd_base_q            <= '0;
            wr_base_q            <= '0;
            row_stride_q         <= '0;
            flt_stride_q         <= '0;
            nt_q                 <= '0;
            nf_q                 <= '0;
            cfg_count_layer_q    <= '0;
            cfg_ifm_size_q       <= '0;
            cfg_ifm_channel_q    <= '0;
            cfg_kernel_size_q    <= '0;
            cfg_num_filter_q     <= '0;
            cfg_maxpool_mode_q   <= 1'b0;
            cfg_maxpool_stride_q <= '0;
            cfg_upsample_mode_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_count_layer_q    <= count_layer;
                        cfg_ifm_size_q       <= ifm_size;
                        cfg_ifm_channel_q    <= ifm_channel;
                        cfg_kernel_size_q    <= kernel_size;
                        cfg_num_filter_q     <= num_filter;
                        cfg_maxpool_mode_q   <= maxpool_mode;
                        cfg_maxpool_stride_q <= maxpool_stride;
                        cfg_upsample_mode_q  <= upsample_mode;
                        rd_base_q            <= start_read_addr;
                        wr_base_q            <= start_write_addr;
                        busy_q               <= 1'b1;
                        state_q              <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    nt_q         <= nt_d;
                    nf_q         <= nf_d;
                    row_stride_q <= row_stride_d;
                    flt_stride_q <= flt_stride_d;
                    flt_q        <= '0;
                    row_q        <= '0;
                    col_q        <= '0;
                    rd_addr_q    <= rd_base_q;
                    wr_addr_q    <= wr_base_q;
                    rd_row_q     <= rd_base_q;
                    wr_row_q     <= wr_base_q;
                    wr_flt_q     <= wr_base_q;
                    // An empty layer retires through ADV, which sees the zero count and heads to FIN.
                    if (nt_d == 6'd0 || nf_d == 8'd0) begin
                        state_q <= S_ADV;
                    end else begin
                        tile_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tile_start_q <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) begin
                        state_q <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (walk_end) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        tile_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                        if (!col_last) begin
                            col_q     <= col_q + 5'd1;
                            rd_addr_q <= rd_addr_q + col_step;
                            wr_addr_q <= wr_addr_q + col_step;
                        end else if (!row_last) begin
                            col_q     <= '0;
                            row_q     <= row_q + 5'd1;
                            rd_row_q  <= rd_row_q + row_stride_q;
                            wr_row_q  <= wr_row_q + row_stride_q;
                            rd_addr_q <= rd_row_q + row_stride_q;
                            wr_addr_q <= wr_row_q + row_stride_q;
                        end else begin
                            col_q     <= '0;
                            row_q     <= '0;
                            flt_q     <= flt_q + 7'd1;
                            rd_row_q  <= rd_base_q;
                            rd_addr_q <= rd_base_q;
                            wr_flt_q  <= wr_flt_q + flt_stride_q;
                            wr_row_q  <= wr_flt_q + flt_stride_q;
                            wr_addr_q <= wr_flt_q + flt_stride_q;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign tile_start         = tile_start_q;
    assign tile_filter_idx    = flt_q;
    assign tile_row_idx       = row_q;
    assign tile_col_idx       = col_q;
    assign tile_rd_addr       = rd_addr_q;
    assign tile_wr_addr       = wr_addr_q;
    assign cfg_count_layer    = cfg_count_layer_q;
    assign cfg_ifm_size       = cfg_ifm_size_q;
    assign cfg_ifm_channel    = cfg_ifm_channel_q;
    assign cfg_kernel_size    = cfg_kernel_size_q;
    assign cfg_num_filter     = cfg_num_filter_q;
    assign cfg_maxpool_mode   = cfg_maxpool_mode_q;
    assign cfg_maxpool_stride = cfg_maxpool_stride_q;
    assign cfg_upsample_mode  = cfg_upsample_mode_q;

endmodule
